// File: rtl/ps2_keys_pkg.sv
// Shared PS/2 set-2 scan-code constants, state encodings and the digit-key lookup
// used by the make-event decoder and the numeric entry buffer.
package ps2_keys_pkg;

  localparam logic [7:0] SC_BREAK = 8'hF0;
  localparam logic [7:0] SC_EXT   = 8'hE0;
  localparam logic [7:0] SC_ENTER = 8'h5A;
  localparam logic [7:0] SC_BKSP  = 8'h66;
  localparam logic [7:0] SC_ESC   = 8'h76;

  typedef enum logic [1:0] {
    P_NORM,
    P_EXT,
    P_BRK,
    P_EXT_BRK
  } prefix_state_t;

  typedef enum logic {
    S_ENTRY,
    S_DONE
  } entry_state_t;

  typedef struct packed {
    logic       hit;
    logic [3:0] digit;
  } digit_hit_t;

  // Main-row and keypad digit keys both map to their BCD value.
  function automatic digit_hit_t sc_to_digit(input logic [7:0] code);
    digit_hit_t r;
    r = '{hit: 1'b1, digit: 4'd0};
    case (code)
      8'h45, 8'h70: r.digit = 4'd0;
      8'h16, 8'h69: r.digit = 4'd1;
      8'h1E, 8'h72: r.digit = 4'd2;
      8'h26, 8'h7A: r.digit = 4'd3;
      8'h25, 8'h6B: r.digit = 4'd4;
      8'h2E, 8'h73: r.digit = 4'd5;
      8'h36, 8'h74: r.digit = 4'd6;
      8'h3D, 8'h6C: r.digit = 4'd7;
      8'h3E, 8'h75: r.digit = 4'd8;
      8'h46, 8'h7D: r.digit = 4'd9;
      default:      r.hit   = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/ps2_make_decoder.sv
// Tracks the E0/F0 prefix bytes of the PS/2 stream and flags genuine make events
// in the same cycle the completing byte is strobed in.
module ps2_make_decoder
  import ps2_keys_pkg::*;
(
  input  logic       clk100,
  input  logic       rst_n,
  input  logic [7:0] scan_code,
  input  logic       new_code,
  output logic       make_evt,
  output logic [7:0] make_code,
  output logic       make_ext
);

  prefix_state_t state;

  always_ff @(posedge clk100 or negedge rst_n) begin
    if (!rst_n) begin
      state <= P_NORM;
    end else if (new_code) begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      unique case (state)
        P_NORM: begin
          if (scan_code == SC_EXT)        state <= P_EXT;
          else if (scan_code == SC_BREAK) state <= P_BRK;
        end
        P_EXT:     state <= (scan_code == SC_BREAK) ? P_EXT_BRK : P_NORM;
        P_BRK:     state <= P_NORM;
        P_EXT_BRK: state <= P_NORM;
        default:   state <= P_NORM;
      endcase
    end
  end

  // The event is combinational so the entry buffer can register its response
  // on the very next edge.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves a latch behind.
    make_evt  = 1'b0;
    make_ext  = 1'b0;
    make_code = scan_code;
    if (new_code) begin
      unique case (state)
        P_NORM:  make_evt = (scan_code != SC_EXT) && (scan_code != SC_BREAK);
        P_EXT: begin
          make_evt = (scan_code != SC_BREAK);
          make_ext = 1'b1;
        end
        default: make_evt = 1'b0;
      endcase
    end
  end

endmodule

// File: rtl/ps2_digit_entry.sv
// Multi-digit BCD entry buffer fed by PS/2 make events; supports backspace, clear
// and an Enter-triggered commit held until the consumer acknowledges it.
module ps2_digit_entry
  import ps2_keys_pkg::*;
#(
  parameter int NUM_DIGITS  = 8,
  parameter int ACCEPT_ZERO = 1
) (
  input  logic                            clk100,
  input  logic                            rst_n,
  input  logic [7:0]                      scan_code,
  input  logic                            new_code,
  input  logic                            entry_ack,
  output logic [4*NUM_DIGITS-1:0]         digits_bcd,
  output logic [$clog2(NUM_DIGITS+1)-1:0] digit_count,
  output logic                            entry_valid,
  output logic                            overflow,
  output logic                            key_error
);

  localparam int DW = 4 * NUM_DIGITS;
  localparam int CW = $clog2(NUM_DIGITS + 1);
  localparam logic [CW-1:0] FULL = CW'(NUM_DIGITS);

  logic         make_evt;
  logic [7:0]   make_code;
  logic         make_ext;
  digit_hit_t   dh;
  logic         is_digit;
  logic         is_enter;
  logic         is_bksp;
  logic         is_clear;
  entry_state_t state;

  ps2_make_decoder u_decoder (
    .clk100    (clk100),
    .rst_n     (rst_n),
    .scan_code (scan_code),
    .new_code  (new_code),
    .make_evt  (make_evt),
    .make_code (make_code),
    .make_ext  (make_ext)
  );

  assign dh       = sc_to_digit(make_code);
  assign is_digit = make_evt && !make_ext && dh.hit &&
                    ((ACCEPT_ZERO != 0) || (dh.digit != 4'd0));
  assign is_enter = make_evt && (make_code == SC_ENTER);
  assign is_bksp  = make_evt && !make_ext && (make_code == SC_BKSP);
  assign is_clear = make_evt && !make_ext && (make_code == SC_ESC);

  always_ff @(posedge clk100 or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_ENTRY;
      digits_bcd  <= '0;
      digit_count <= '0;
      entry_valid <= 1'b0;
      overflow    <= 1'b0;
      key_error   <= 1'b0;
    end else begin
      overflow  <= 1'b0;
      key_error <= 1'b0;
      unique case (state)
        S_ENTRY: begin
          if (is_digit) begin
            if (digit_count == FULL) begin
              overflow <= 1'b1;
            end else begin
              // Shift left one nibble; the newest digit lands in the low nibble.
              digits_bcd  <= DW'({digits_bcd, dh.digit});
              digit_count <= digit_count + CW'(1);
            end
          end else if (is_bksp) begin
            if (digit_count != '0) begin
              digits_bcd  <= digits_bcd >> 4;
              digit_count <= digit_count - CW'(1);
            end
          end else if (is_clear) begin
            digits_bcd  <= '0;
            digit_count <= '0;
          end else if (is_enter) begin
            if (digit_count != '0) begin
              state       <= S_DONE;
              entry_valid <= 1'b1;
            end else begin
              key_error <= 1'b1;
            end
          end
        end
        S_DONE: begin
          // Buffer stays frozen; key events are dropped, even alongside the ack.
          if (entry_ack) begin
            state       <= S_ENTRY;
            digits_bcd  <= '0;
            digit_count <= '0;
            entry_valid <= 1'b0;
          end
        end
        default: state <= S_ENTRY;
      endcase
    end
  end

endmodule

// File: tb/tb_ps2_digit_entry.sv
// Directed and randomized bench for ps2_digit_entry against a queue-based model
// of the keystroke rules.
module tb_ps2_digit_entry;

  localparam int N = 4;

  logic        clk100 = 1'b0;
  logic        rst_n;
  logic [7:0]  scan_code;
  logic        new_code;
  logic        entry_ack;
  logic [15:0] digits_bcd;
  logic [2:0]  digit_count;
  logic        entry_valid;
  logic        overflow;
  logic        key_error;
  logic [15:0] digits_bcd_nz;
  logic [2:0]  digit_count_nz;
  logic        entry_valid_nz;
  logic        overflow_nz;
  logic        key_error_nz;

  ps2_digit_entry #(.NUM_DIGITS(N), .ACCEPT_ZERO(1)) u_dut (
    .clk100      (clk100),
    .rst_n       (rst_n),
    .scan_code   (scan_code),
    .new_code    (new_code),
    .entry_ack   (entry_ack),
    .digits_bcd  (digits_bcd),
    .digit_count (digit_count),
    .entry_valid (entry_valid),
    .overflow    (overflow),
    .key_error   (key_error)
  );

  ps2_digit_entry #(.NUM_DIGITS(N), .ACCEPT_ZERO(0)) u_dut_nz (
    .clk100      (clk100),
    .rst_n       (rst_n),
    .scan_code   (scan_code),
    .new_code    (new_code),
    .entry_ack   (entry_ack),
    .digits_bcd  (digits_bcd_nz),
    .digit_count (digit_count_nz),
    .entry_valid (entry_valid_nz),
    .overflow    (overflow_nz),
    .key_error   (key_error_nz)
  );

  always #5 clk100 = ~clk100;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: the held digits as a queue, newest at the back.
  int   q[$];
  bit   m_done, m_brk, m_ext, m_ovf, m_kerr;
  logic [7:0] digit_codes [20] = '{
    8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46,
    8'h70, 8'h69, 8'h72, 8'h7A, 8'h6B, 8'h73, 8'h74, 8'h6C, 8'h75, 8'h7D};

  function automatic int code_digit(input logic [7:0] c);
    for (int i = 0; i < 20; i++) if (digit_codes[i] == c) return i % 10;
    return -1;
  endfunction

  function automatic logic [15:0] model_bcd();
    logic [15:0] v = '0;
    for (int i = 0; i < q.size(); i++) v = (v << 4) | 16'(q[i]);
    return v;
  endfunction

  task automatic model_reset();
    q.delete();
    m_done = 0; m_brk = 0; m_ext = 0; m_ovf = 0; m_kerr = 0;
  endtask

  task automatic model_step(input bit valid, input logic [7:0] b, input bit ack);
    bit evt = 0;
    bit eext = 0;
    int d;
    m_ovf = 0;
    m_kerr = 0;
    if (valid) begin
      if (m_brk) begin
        m_brk = 0; m_ext = 0;
      end else if (b == 8'hF0) begin
        m_brk = 1;
      end else if (b == 8'hE0 && !m_ext) begin
        m_ext = 1;
      end else begin
        evt = 1; eext = m_ext; m_ext = 0;
      end
    end
    if (m_done) begin
      if (ack) begin
        m_done = 0;
        q.delete();
      end
    end else if (evt) begin
      d = code_digit(b);
      if (!eext && d >= 0) begin
        if (q.size() == N) m_ovf = 1;
        else q.push_back(d);
      end else if (b == 8'h5A) begin
        if (q.size() > 0) m_done = 1;
        else m_kerr = 1;
      end else if (!eext && b == 8'h66) begin
        if (q.size() > 0) void'(q.pop_back());
      end else if (!eext && b == 8'h76) begin
        q.delete();
      end
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, "_bcd"}, 32'(digits_bcd), 32'(model_bcd()));
    check({tag, "_cnt"}, 32'(digit_count), 32'(q.size()));
    check({tag, "_valid"}, 32'(entry_valid), 32'(m_done));
    check({tag, "_ovf"}, 32'(overflow), 32'(m_ovf));
    check({tag, "_kerr"}, 32'(key_error), 32'(m_kerr));
  endtask

  // Called at a falling edge; applies inputs for exactly one rising edge.
  task automatic step(input bit valid, input logic [7:0] b, input bit ack, input string tag);
    scan_code = b;
    new_code  = valid;
    entry_ack = ack;
    @(negedge clk100);
    new_code  = 1'b0;
    entry_ack = 1'b0;
    model_step(valid, b, ack);
    check_all(tag);
  endtask

  task automatic key(input logic [7:0] c, input string tag);
    step(1, c, 0, tag);
    step(1, 8'hF0, 0, tag);
    step(1, c, 0, tag);
  endtask

  task automatic do_reset(input string tag);
    #2 rst_n = 1'b0;
    model_reset();
    #1 check_all(tag);
    @(negedge clk100);
    rst_n = 1'b1;
  endtask

  initial begin
    int r;
    logic [7:0] b;
    rst_n = 1'b0; scan_code = '0; new_code = 1'b0; entry_ack = 1'b0;
    model_reset();
    repeat (3) @(negedge clk100);
    check_all("reset");
    rst_n = 1'b1;
    @(negedge clk100);

    // Zero keys only count when ACCEPT_ZERO is set.
    step(1, 8'h45, 0, "zero_main");
    check("az0_cnt", 32'(digit_count_nz), 32'd0);
    step(1, 8'hF0, 0, "zero_brk");
    step(1, 8'h45, 0, "zero_brk2");
    step(1, 8'h70, 0, "kp_zero");
    check("az0_kp_cnt", 32'(digit_count_nz), 32'd0);
    check("az1_kp_cnt", 32'(digit_count), 32'd2);
    step(1, 8'h76, 0, "clr0");

    // Break codes never add digits; back-to-back strobes.
    step(1, 8'h16, 0, "t1"); step(1, 8'hF0, 0, "t1"); step(1, 8'h16, 0, "t1");
    step(1, 8'h1E, 0, "t1"); step(1, 8'hF0, 0, "t1"); step(1, 8'h1E, 0, "t1");
    step(1, 8'h26, 0, "t1"); step(1, 8'hF0, 0, "t1"); step(1, 8'h26, 0, "t1");
    check("t1_bcd_const", 32'(digits_bcd), 32'h0123);
    check("t1_cnt_const", 32'(digit_count), 32'd3);
    step(1, 8'h76, 0, "clr1");

    // Fill to capacity, then overflow.
    key(8'h16, "t2"); key(8'h1E, "t2"); key(8'h26, "t2"); key(8'h25, "t2");
    check("t2_full_bcd", 32'(digits_bcd), 32'h1234);
    check("t2_full_cnt", 32'(digit_count), 32'd4);
    step(1, 8'h2E, 0, "t2_ovf");
    check("t2_ovf_pulse", 32'(overflow), 32'd1);
    step(1, 8'hF0, 0, "t2_ovf_end");
    check("t2_ovf_gone", 32'(overflow), 32'd0);
    step(1, 8'h2E, 0, "t2");
    check("t2_unchanged", 32'(digits_bcd), 32'h1234);
    step(1, 8'h76, 0, "clr2");

    // Backspace, clear, backspace on empty.
    key(8'h3D, "t3"); key(8'h3E, "t3"); key(8'h46, "t3"); key(8'h66, "t3");
    check("t3_bksp", 32'(digits_bcd), 32'h0078);
    key(8'h76, "t3");
    check("t3_clear", 32'(digit_count), 32'd0);
    key(8'h66, "t3_empty_bksp");

    // Commit via extended Enter, ignored keys while done, ack.
    key(8'h25, "t4"); key(8'h1E, "t4");
    step(1, 8'hE0, 0, "t4_e0");
    step(1, 8'h5A, 0, "t4_enter");
    check("t4_valid", 32'(entry_valid), 32'd1);
    check("t4_bcd", 32'(digits_bcd), 32'h0042);
    step(1, 8'hE0, 0, "t4"); step(1, 8'hF0, 0, "t4"); step(1, 8'h5A, 0, "t4");
    key(8'h26, "t4_frozen");
    check("t4_frozen_bcd", 32'(digits_bcd), 32'h0042);
    step(0, 8'h00, 1, "t4_ack");
    check("t4_ack_valid", 32'(entry_valid), 32'd0);

    // Ack coinciding with a break prefix byte.
    key(8'h25, "t5"); step(1, 8'h5A, 0, "t5_enter");
    step(1, 8'hF0, 1, "t5_ack_brk");
    step(1, 8'h16, 0, "t5_consumed");
    check("t5_empty", 32'(digit_count), 32'd0);
    step(1, 8'h1E, 0, "t5_next");
    check("t5_bcd", 32'(digits_bcd), 32'h0002);
    step(1, 8'h76, 0, "clr5");

    // Enter on empty buffer, then reset in the middle of a break sequence.
    step(1, 8'h5A, 0, "t6_kerr");
    check("t6_kerr_pulse", 32'(key_error), 32'd1);
    step(0, 8'h00, 0, "t6_idle");
    key(8'h36, "t6");
    step(1, 8'hF0, 0, "t6_brk");
    do_reset("t6_rst");
    step(1, 8'h16, 0, "t6_after_rst");
    check("t6_after_rst_bcd", 32'(digits_bcd), 32'h0001);

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++) begin
      r = $urandom_range(0, 15);
      if (r < 8)       b = digit_codes[$urandom_range(0, 19)];
      else if (r < 10) b = 8'hF0;
      else if (r == 10) b = 8'hE0;
      else if (r == 11) b = 8'h5A;
      else if (r == 12) b = 8'h66;
      else if (r == 13) b = 8'h76;
      else              b = 8'($urandom);
      step($urandom_range(0, 7) != 0, b, $urandom_range(0, 5) == 0, "rnd");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ps2_digit_entry.md
Name: ps2_digit_entry

Overview:
- Multi-digit numeric entry buffer between the PS/2 receiver and the display / RSA operand path.
- Consumes raw scan-code bytes with a one-cycle strobe and filters out break and extended sequences.
- Accumulates up to NUM_DIGITS BCD digits; supports backspace and clear.
- Commits the operand on Enter through a valid/ack handshake.

Parameters:
- NUM_DIGITS, 8, maximum digits held (>=1)
- ACCEPT_ZERO, 1, 1 = '0' keys (0x45, keypad 0x70) append digit 0; 0 = ignored

Ports:
- clk100  input  1  system clock, 100 MHz
- rst_n  input  1  asynchronous active-low reset
- scan_code  input  8  byte from PS/2 receiver, valid when new_code=1
- new_code  input  1  one-cycle strobe per received byte
- entry_ack  input  1  consumer accepts committed operand
- digits_bcd  output  4*NUM_DIGITS  live buffer; newest digit in bits [3:0]
- digit_count  output  $clog2(NUM_DIGITS+1)  digits currently held
- entry_valid  output  1  operand committed, buffer frozen
- overflow  output  1  one-cycle pulse: digit key pressed while full
- key_error  output  1  one-cycle pulse: Enter pressed with empty buffer

Behaviour:
- Reset (async assert, sync release): digits_bcd=0, digit_count=0, entry_valid=0, overflow=0, key_error=0; prefix FSM=P_NORM; entry FSM=S_ENTRY.
- Prefix FSM advances only on new_code=1 and runs in every entry state, so prefix tracking is never lost.
  - P_NORM: 0xE0 -> P_EXT; 0xF0 -> P_BRK; otherwise emit make event (code, ext=0), stay in P_NORM.
  - P_EXT: 0xF0 -> P_EXT_BRK; otherwise emit make (code, ext=1) -> P_NORM.
  - P_BRK: any byte -> P_NORM, no event.
  - P_EXT_BRK: any byte -> P_NORM, no event.
- Make-event map:
  - Digits, ext=0: 0x45/0x16/0x1E/0x26/0x25/0x2E/0x36/0x3D/0x3E/0x46 = 0..9; keypad 0x70/0x69/0x72/0x7A/0x6B/0x73/0x74/0x6C/0x75/0x7D = 0..9.
  - Enter: 0x5A with ext=0 or ext=1.
  - Backspace: 0x66, ext=0.
  - Clear: 0x76 (Esc), ext=0.
  - All other codes are ignored. Extended codes other than 0x5A are ignored.
- Entry FSM, S_ENTRY:
  - Digit, count<N: digits_bcd <= {digits_bcd[4N-5:0], d}; count+1.
  - Digit, count==N: buffer unchanged; overflow=1 for one cycle.
  - Backspace, count>0: digits_bcd <= {4'h0, digits_bcd[4N-1:4]}; count-1. With count==0: no-op.
  - Clear: digits_bcd=0, count=0.
  - Enter, count>0: -> S_DONE, entry_valid=1.
  - Enter, count==0: key_error=1 for one cycle; stay in S_ENTRY.
- Entry FSM, S_DONE:
  - entry_valid held at 1; digits_bcd and count frozen.
  - All make events are ignored (no overflow or key_error pulses).
  - entry_ack=1: -> S_ENTRY, digits_bcd=0, count=0, entry_valid=0, all on the next edge.
- entry_ack in S_ENTRY is ignored.
- Simultaneous entry_ack and make event in S_DONE: ack wins and the make event is dropped. The prefix FSM still consumes the byte.
- Latency: every output update is registered, one cycle after the new_code edge (or after the entry_ack edge).
- Bytes arriving while new_code=0 are ignored. Back-to-back strobes on consecutive cycles must be handled.
- Reset mid-sequence (e.g. after 0xF0) returns to P_NORM; the next byte is treated as a make.

Decomposition:
- Package ps2_keys_pkg:
  - scan-code localparams: SC_BREAK=8'hF0, SC_EXT=8'hE0, SC_ENTER, SC_BKSP, SC_ESC;
  - prefix state enum; entry state enum;
  - function sc_to_digit(code) returning {hit, digit[3:0]}.
- Sub-module ps2_make_decoder: holds the prefix FSM; outputs make_evt, make_code[7:0], make_ext.
- ps2_digit_entry instantiates ps2_make_decoder and contains the entry FSM and digit buffer.

Test Plan:
- N=4. Bytes 16,F0,16,1E,F0,1E,26,F0,26 -> digits_bcd=16'h0123, count=3. No digit added by break codes.
- N=4. Keys 1..5 (make+break each) -> after the 4th digit digits_bcd=16'h1234, count=4; 5th digit gives one overflow pulse, buffer unchanged.
- Keys 7,8,9 then 66 -> digits_bcd=16'h0078, count=2. Then 76 -> digits_bcd=0, count=0. Then 66 on empty -> no change.
- Keys 4,2 then E0,5A -> entry_valid=1 one cycle later, digits_bcd=16'h0042. Key 3 during S_DONE -> no change. entry_ack pulse -> entry_valid=0, count=0.
- In S_DONE, entry_ack coincides with new_code=F0; next byte 16 -> buffer stays empty (break consumed). Following 1E -> digits_bcd=16'h0002.
- Enter with empty buffer -> key_error pulse, entry_valid=0. Reset asserted after byte F0, released, then byte 16 -> digits_bcd=16'h0001.
- ACCEPT_ZERO=0: key 45 -> ignored, count=0.
